mac_accumulator_5_bit: RTL and testbench

//  Downstream consumer of multiplier_W_tree_5_bit. Accepts a stream of 5-bit

---
 rtl/mac_accumulator_5_bit.sv | 157 +++++++++++++++
 tb/tb_mac_accumulator_5_bit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator_5_bit.sv
// ---------------------------------------------------------------------------
// mac_accumulator_5_bit
//
// Purpose:
//   Streams 5-bit unsigned operand pairs into a registered multiplier
//   (multiplier_W_tree_5_bit). It sums N_TERMS 10-bit products into one
//   ACC_W-bit dot-product result, then presents that result on a
//   valid/ready output handshake.
//
// Optional feature (compile-time macro SATURATE_EN):
//   Defined   : on overflow acc_out clamps to 2^ACC_W-1. It stays there for
//               the remaining terms of the result.
//   Undefined : acc_out wraps modulo 2^ACC_W.
//   overflow is flagged identically in both builds.
//
// Ports:
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   in_valid    in   1      operand pair valid
//   in_ready    out  1      block can accept an operand pair (combinational)
//   in0, in1    in   5      operands A and B, unsigned
//   out_valid   out  1      acc_out holds a completed result
//   out_ready   in   1      consumer takes the result
//   acc_out     out  ACC_W  accumulated sum of N_TERMS products
//   term_count  out  CNT_W  products added to the current result so far
//   overflow    out  1      sticky; sum exceeded 2^ACC_W-1 in this result
// ---------------------------------------------------------------------------

// 5x5 unsigned multiplier. The five partial products are reduced by a
// small adder tree.
module multiplier_W_tree_5_bit (
    input  logic [4:0] in0,
    input  logic [4:0] in1,
    output logic [9:0] multi_out
);
    logic [9:0] pp [5];
    logic [9:0] sum_01;
    logic [9:0] sum_23;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_pp
            assign pp[gi] = 10'({5{in1[gi]}} & in0) << gi;
        end
    endgenerate

    assign sum_01    = pp[0] + pp[1];
    assign sum_23    = pp[2] + pp[3];
    assign multi_out = (sum_01 + sum_23) + pp[4];
endmodule

module mac_accumulator_5_bit #(
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in0,
    input  logic [4:0]       in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_count,
    output logic             overflow
);
    typedef enum logic {ACCUM, DONE} state_t;

    state_t           state_reg;
    logic [4:0]       op_a_reg;
    logic [4:0]       op_b_reg;
    logic             op_valid_reg;
    logic [CNT_W-1:0] accept_cnt_reg;

    logic [9:0]       product;
    logic [ACC_W:0]   sum_next;
    logic [ACC_W-1:0] acc_next;
    logic             accept;
    logic             last_term;

    multiplier_W_tree_5_bit u_mult (
        .in0       (op_a_reg),
        .in1       (op_b_reg),
        .multi_out (product)
    );

    // Once accept_cnt reaches N_TERMS, further beats are refused. This
    // holds until the result has been handed off.
    assign in_ready  = !reset && (state_reg == ACCUM) &&
                       (accept_cnt_reg < CNT_W'(N_TERMS));
    assign accept    = in_valid && in_ready;
    assign last_term = (term_count == CNT_W'(N_TERMS - 1));

    // The extra top bit of the sum is the carry out of the accumulator width.
    assign sum_next  = {1'b0, acc_out} + (ACC_W + 1)'(product);

`ifdef SATURATE_EN
    // A clamped accumulator remains at its maximum. Any further non-zero
    // product overflows again, and clamping reapplies.
    assign acc_next  = sum_next[ACC_W] ? {ACC_W{1'b1}} : sum_next[ACC_W-1:0];
`else
    assign acc_next  = sum_next[ACC_W-1:0];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= ACCUM;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            op_valid_reg   <= 1'b0;
            accept_cnt_reg <= '0;
            acc_out        <= '0;
            term_count     <= '0;
            overflow       <= 1'b0;
            out_valid      <= 1'b0;
        end else begin
            op_valid_reg <= accept;
            if (accept) begin
                op_a_reg       <= in0;
                op_b_reg       <= in1;
                accept_cnt_reg <= accept_cnt_reg + 1'b1;
            end

            case (state_reg)
                ACCUM: begin
                    if (op_valid_reg) begin
                        acc_out    <= acc_next;
                        term_count <= term_count + 1'b1;
                        if (sum_next[ACC_W]) begin
                            overflow <= 1'b1;
                        end
                        if (last_term) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // No accept can occur in DONE because in_ready is low.
                    // As a result, the accept_cnt clear below never races
                    // an increment.
                    if (out_ready) begin
                        state_reg      <= ACCUM;
                        acc_out        <= '0;
                        term_count     <= '0;
                        accept_cnt_reg <= '0;
                        overflow       <= 1'b0;
                        out_valid      <= 1'b0;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_accumulator_5_bit.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator_5_bit
//
// Purpose:
//   Self-checking bench for mac_accumulator_5_bit. There are three instances:
//     main : ACC_W=16, N_TERMS=4
//     ovfl : ACC_W=10, N_TERMS=4  (overflow / saturation behaviour)
//     one  : ACC_W=16, N_TERMS=1
//   Expected results come from constants, or from a plain-arithmetic model:
//   the sum of products, then wrap or clamp.
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mac_accumulator_5_bit;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // main instance
    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_ovf;
    logic [4:0]  m_in0, m_in1;
    logic [15:0] m_acc;
    logic [3:0]  m_tc;

    // overflow instance
    logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_ovf;
    logic [4:0]  o_in0, o_in1;
    logic [9:0]  o_acc;
    logic [3:0]  o_tc;

    // single-term instance
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_ovf;
    logic [4:0]  n_in0, n_in1;
    logic [15:0] n_acc;
    logic [3:0]  n_tc;

    mac_accumulator_5_bit #(.ACC_W(16), .N_TERMS(4), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in0(m_in0), .in1(m_in1), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .acc_out(m_acc), .term_count(m_tc), .overflow(m_ovf));

    mac_accumulator_5_bit #(.ACC_W(10), .N_TERMS(4), .CNT_W(4)) dut_ovfl (
        .clock(clock), .reset(reset), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .in0(o_in0), .in1(o_in1), .out_valid(o_out_valid), .out_ready(o_out_ready),
        .acc_out(o_acc), .term_count(o_tc), .overflow(o_ovf));

    mac_accumulator_5_bit #(.ACC_W(16), .N_TERMS(1), .CNT_W(4)) dut_one (
        .clock(clock), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in0(n_in0), .in1(n_in1), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .acc_out(n_acc), .term_count(n_tc), .overflow(n_ovf));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][4:0] a;
        logic [3:0][4:0] b;
        int              gap;
        int              hold;
        int              exp_acc;
    } vec_t;

    function automatic vec_t mk(input int a0, b0, a1, b1, a2, b2, a3, b3,
                                input int gap, hold, exp_acc);
        vec_t v;
        v.a[0] = 5'(a0); v.b[0] = 5'(b0);
        v.a[1] = 5'(a1); v.b[1] = 5'(b1);
        v.a[2] = 5'(a2); v.b[2] = 5'(b2);
        v.a[3] = 5'(a3); v.b[3] = 5'(b3);
        v.gap = gap; v.hold = hold; v.exp_acc = exp_acc;
        return v;
    endfunction

    // Reference: the plain dot product of the four pairs.
    function automatic int dot(input vec_t v);
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'(v.a[k]) * int'(v.b[k]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one full result through the main instance, then hand it off.
    task automatic run_main(input vec_t v, output int acc, output int ovf);
        int w;
        int c;
        m_out_ready = (v.hold == 0);
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!m_in_ready && w < 20) begin tick(); w++; end
            if (!m_in_ready) check("in_ready_timeout", 32'(m_in_ready), 1);
            m_in_valid = 1'b1; m_in0 = v.a[k]; m_in1 = v.b[k];
            tick();
            m_in_valid = 1'b0;
            // The previous beat's product lands on the same edge as this accept.
            check("term_count_step", 32'(m_tc), 32'(k));
            if (v.gap > 0) begin
                repeat (v.gap) tick();
                check("term_count_gap", 32'(m_tc), 32'(k + 1));
            end
        end
        c = 0;
        while (!m_out_valid && c < 10) begin tick(); c++; end
        check("out_valid_seen", 32'(m_out_valid), 1);
        if (v.gap == 0) check("out_latency", 32'(c), 1);
        acc = int'(m_acc);
        ovf = int'(m_ovf);
        check("done_term_count", 32'(m_tc), 4);
        check("done_in_ready", 32'(m_in_ready), 0);
        for (int h = 0; h < v.hold; h++) begin
            m_in_valid = 1'b1; m_in0 = 5'd7; m_in1 = 5'd7;
            tick();
            check("hold_acc_stable", 32'(m_acc), 32'(acc));
            check("hold_in_ready", 32'(m_in_ready), 0);
            check("hold_out_valid", 32'(m_out_valid), 1);
        end
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        tick();
        check("clear_out_valid", 32'(m_out_valid), 0);
        check("clear_acc", 32'(m_acc), 0);
        check("clear_in_ready", 32'(m_in_ready), 1);
        check("clear_term_count", 32'(m_tc), 0);
    endtask

    // Four back-to-back beats into the 10-bit instance, with the result handed off.
    task automatic run_ovfl(input vec_t v, output int acc, output int ovf);
        int c;
        o_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovfl_in_ready", 32'(o_in_ready), 1);
            o_in_valid = 1'b1; o_in0 = v.a[k]; o_in1 = v.b[k];
            tick();
        end
        o_in_valid = 1'b0;
        c = 0;
        while (!o_out_valid && c < 10) begin tick(); c++; end
        check("ovfl_out_valid", 32'(o_out_valid), 1);
        acc = int'(o_acc);
        ovf = int'(o_ovf);
        tick();
        check("ovfl_clear_acc", 32'(o_acc), 0);
        check("ovfl_clear_flag", 32'(o_ovf), 0);
    endtask

    vec_t vecs[6];
    vec_t v;
    int   acc, ovf, exp_acc, exp_ovf, s;

    initial begin
        vecs[0] = mk(1, 6, 5, 10, 31, 31, 0, 0, 0, 0, 1017);
        vecs[1] = mk(1, 6, 5, 10, 31, 31, 0, 0, 1, 0, 1017);
        vecs[2] = mk(1, 6, 5, 10, 31, 31, 0, 0, 0, 5, 1017);
        vecs[3] = mk(2, 3, 4, 5, 6, 7, 8, 9, 2, 1, 140);
        vecs[4] = mk(31, 31, 31, 31, 31, 31, 31, 31, 0, 0, 3844);
        vecs[5] = mk(0, 17, 9, 0, 3, 3, 30, 2, 1, 2, 69);

        reset = 1'b1;
        m_in_valid = 0; m_in0 = 0; m_in1 = 0; m_out_ready = 0;
        o_in_valid = 0; o_in0 = 0; o_in1 = 0; o_out_ready = 0;
        n_in_valid = 0; n_in0 = 0; n_in1 = 0; n_out_ready = 0;
        #1;
        check("rst_in_ready", 32'(m_in_ready), 0);
        check("rst_out_valid", 32'(m_out_valid), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(m_in_ready), 1);
        check("post_rst_acc", 32'(m_acc), 0);
        check("post_rst_term_count", 32'(m_tc), 0);
        check("post_rst_overflow", 32'(m_ovf), 0);

        // Table-driven results on the main instance
        foreach (vecs[i]) begin
            run_main(vecs[i], acc, ovf);
            check("row_acc", 32'(acc), 32'(vecs[i].exp_acc));
            check("row_overflow", 32'(ovf), 0);
        end

        // Randomized results against the dot-product model
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                v.a[k] = 5'($urandom_range(0, 31));
                v.b[k] = 5'($urandom_range(0, 31));
            end
            v.gap = int'($urandom_range(0, 2));
            v.hold = int'($urandom_range(0, 3));
            v.exp_acc = dot(v);
            run_main(v, acc, ovf);
            check("rand_acc", 32'(acc), 32'(v.exp_acc));
            check("rand_overflow", 32'(ovf), 0);
        end

        // Reset mid-result discards the partial sum immediately
        m_out_ready = 1'b1;
        m_in_valid = 1'b1; m_in0 = 5'd3; m_in1 = 5'd3; tick();
        m_in0 = 5'd2; m_in1 = 5'd2; tick();
        m_in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_acc", 32'(m_acc), 0);
        check("midrst_term_count", 32'(m_tc), 0);
        check("midrst_out_valid", 32'(m_out_valid), 0);
        check("midrst_in_ready", 32'(m_in_ready), 0);
        check("midrst_overflow", 32'(m_ovf), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        run_main(mk(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 4), acc, ovf);
        check("after_rst_acc", 32'(acc), 4);
        check("after_rst_overflow", 32'(ovf), 0);

        // 10-bit accumulator: overflow flag plus wrap or clamp
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                v.a[k] = (r == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                v.b[k] = (r == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            end
            s = dot(v);
            exp_ovf = (s > 1023) ? 1 : 0;
`ifdef SATURATE_EN
            exp_acc = (s > 1023) ? 1023 : s;
`else
            exp_acc = s % 1024;
`endif
            run_ovfl(v, acc, ovf);
            check("ovfl_acc", 32'(acc), 32'(exp_acc));
            check("ovfl_flag", 32'(ovf), 32'(exp_ovf));
        end

        // Single-term instance
        n_out_ready = 1'b1;
        n_in_valid = 1'b1; n_in0 = 5'd31; n_in1 = 5'd31;
        tick();
        n_in_valid = 1'b0;
        check("one_not_yet_valid", 32'(n_out_valid), 0);
        tick();
        check("one_out_valid", 32'(n_out_valid), 1);
        check("one_acc", 32'(n_acc), 961);
        check("one_term_count", 32'(n_tc), 1);
        check("one_in_ready_done", 32'(n_in_ready), 0);
        tick();
        check("one_cleared", 32'(n_out_valid), 0);
        check("one_in_ready_back", 32'(n_in_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
